// File: rtl/cic_decim_sequencer_pkg.sv
// Shared types and constants for the CIC decimation sequencer.
package cic_pkg;

  localparam int SeqStateBits         = 2;
  localparam int DefaultWarmupSamples = 6;

  typedef enum logic [SeqStateBits-1:0] {
    IDLE   = 2'b00,
    WARMUP = 2'b01,
    RUN    = 2'b10
  } seq_state_e;

endpackage

// File: rtl/cic_decim_sequencer_if.sv
// Compensator and downstream handshake bundle seen by the CIC decimation sequencer.
interface cic_decim_sequencer_if;

  logic comp_in_valid;
  logic comp_out_valid;
  logic comp_out_ready;
  logic out_valid;
  logic out_ready;

  modport master (
    output comp_in_valid,
    output comp_out_ready,
    output out_valid,
    input  comp_out_valid,
    input  out_ready
  );

  modport slave (
    input  comp_in_valid,
    input  comp_out_ready,
    input  out_valid,
    output comp_out_valid,
    output out_ready
  );

endinterface

// File: rtl/cic_decim_sequencer_phase_counter.sv
// Modulo-R input counter; emits a registered one-cycle wrap strobe on every R-th enabled input.
module cic_phase_counter #(
  parameter int RatioBits = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 en,
  input  logic [RatioBits-1:0] ratio_q,
  output logic                 wrap
);

  localparam logic [RatioBits-1:0] One = RatioBits'(1);

  logic [RatioBits-1:0] phase_r;
  logic                 wrap_r;
  logic                 last_s;

  assign last_s = (phase_r == (ratio_q - One));

  // Phase register and wrap strobe; clear also cancels a pending strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= {RatioBits{1'b0}};
      wrap_r  <= 1'b0;
    end else if (clear) begin
      phase_r <= {RatioBits{1'b0}};
      wrap_r  <= 1'b0;
    end else if (en) begin
      if (last_s) begin
        phase_r <= {RatioBits{1'b0}};
        wrap_r  <= 1'b1;
      end else begin
        phase_r <= phase_r + One;
        wrap_r  <= 1'b0;
      end
    end else begin
      wrap_r <= 1'b0;
    end
  end

  assign wrap = wrap_r;

endmodule

// File: rtl/cic_decim_sequencer.sv
// CIC decimation sequencer: strobe generation, compensator gating, warm-up discard, drop counting.
// Optional drop counter enabled by defining CIC_DECIM_SEQUENCER_DROP_COUNT_EN.
module cic_decim_sequencer
  import cic_pkg::*;
#(
  parameter int RatioBits     = 8,
  parameter int WarmupSamples = DefaultWarmupSamples,
  parameter int DropCountBits = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [RatioBits-1:0]     ratio,
  input  logic                     ratio_load,
  input  logic                     in_valid,
  output logic                     decim_strobe,
  cic_decim_sequencer_if.master    bus,
  output logic [DropCountBits-1:0] drop_count,
  output logic [SeqStateBits-1:0]  state
);

  localparam int                  WarmBits = $clog2(WarmupSamples + 1);
  localparam logic [WarmBits-1:0] WarmLast = WarmBits'(WarmupSamples - 1);

  seq_state_e           state_r;
  seq_state_e           state_next_s;
  logic [RatioBits-1:0] ratio_q_r;
  logic [WarmBits-1:0]  warm_r;
  logic                 active_s;
  logic                 wrap_s;
  logic                 issue_s;
  logic                 comp_out_ready_s;
  logic                 out_valid_s;

  assign active_s = (state_r == WARMUP) || (state_r == RUN);

  cic_phase_counter #(.RatioBits(RatioBits)) u_phase (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (ratio_load),
    .en      (in_valid & active_s & ~ratio_load),
    .ratio_q (ratio_q_r),
    .wrap    (wrap_s)
  );

  assign decim_strobe = wrap_s & active_s;
  assign issue_s      = decim_strobe & (~bus.comp_out_valid | comp_out_ready_s);

  // Per-state handshake routing: only RUN exposes compensator output downstream.
  always_comb begin
    comp_out_ready_s = 1'b1;
    out_valid_s      = 1'b0;
    case (state_r)
      RUN: begin
        comp_out_ready_s = bus.out_ready;
        out_valid_s      = bus.comp_out_valid;
      end
      default: begin
        comp_out_ready_s = 1'b1;
        out_valid_s      = 1'b0;
      end
    endcase
  end

  assign bus.comp_out_ready = comp_out_ready_s;
  assign bus.out_valid      = out_valid_s;
  assign bus.comp_in_valid  = issue_s;

  // Next-state logic; a load overrides whatever the current state would do.
  always_comb begin
    state_next_s = state_r;
    if (ratio_load) begin
      if (ratio != {RatioBits{1'b0}}) begin
        state_next_s = WARMUP;
      end else begin
        state_next_s = IDLE;
      end
    end else begin
      case (state_r)
        IDLE:   state_next_s = IDLE;
        WARMUP: begin
          if (bus.comp_out_valid && (warm_r == WarmLast)) begin
            state_next_s = RUN;
          end else begin
            state_next_s = WARMUP;
          end
        end
        RUN:     state_next_s = RUN;
        default: state_next_s = IDLE;
      endcase
    end
  end

  // State, latched ratio and warm-up count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      ratio_q_r <= {RatioBits{1'b0}};
      warm_r    <= {WarmBits{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (ratio_load) begin
        if (ratio != {RatioBits{1'b0}}) begin
          ratio_q_r <= ratio;
        end
        warm_r <= {WarmBits{1'b0}};
      end else if ((state_r == WARMUP) && bus.comp_out_valid) begin
        warm_r <= warm_r + WarmBits'(1);
      end
    end
  end

  assign state = state_r;

`ifdef CIC_DECIM_SEQUENCER_DROP_COUNT_EN
  logic                     drop_s;
  logic [DropCountBits-1:0] drop_count_r;

  assign drop_s = decim_strobe & ~issue_s;

  // Saturating count of decimated samples the compensator could not accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count_r <= {DropCountBits{1'b0}};
    end else if (drop_s && (drop_count_r != {DropCountBits{1'b1}})) begin
      drop_count_r <= drop_count_r + DropCountBits'(1);
    end
  end

  assign drop_count = drop_count_r;
`else
  assign drop_count = {DropCountBits{1'b0}};
`endif

endmodule

// File: tb/tb_cic_decim_sequencer.sv
// Directed, table-driven bench for cic_decim_sequencer with a 2-cycle compensator model.
module tb_cic_decim_sequencer;
  import cic_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ratio;
  logic        ratio_load;
  logic        in_valid;
  logic        decim_strobe;
  logic [15:0] drop_count;
  logic [1:0]  state;
  logic        model_mode;
  logic        force_cov;
  logic [1:0]  pipe = 2'b00;

  int tests = 0;
  int fails = 0;

  cic_decim_sequencer_if bus ();

  always #5 clk = ~clk;

  always @(posedge clk) pipe <= {pipe[0], bus.comp_in_valid};
  assign bus.comp_out_valid = model_mode ? pipe[1] : force_cov;

  cic_decim_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ratio        (ratio),
    .ratio_load   (ratio_load),
    .in_valid     (in_valid),
    .decim_strobe (decim_strobe),
    .bus          (bus),
    .drop_count   (drop_count),
    .state        (state)
  );

  typedef struct {
    logic       load;
    logic [7:0] ratio;
    logic       iv;
    logic       exp_strobe;
    logic [1:0] exp_state;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int occ;
    int strobes;
    int issues;
    int exp_drop;

    ratio = 8'd5; ratio_load = 1'b0; in_valid = 1'b1;
    model_mode = 1'b0; force_cov = 1'b0; bus.out_ready = 1'b1;

    // Long reset with activity on the inputs
    for (int i = 0; i < 1000; i++) begin
      step();
      ratio_load = ~ratio_load;
    end
    check("rst_state", int'(state), 0);
    check("rst_decim_strobe", int'(decim_strobe), 0);
    check("rst_comp_in_valid", int'(bus.comp_in_valid), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_comp_out_ready", int'(bus.comp_out_ready), 1);
    check("rst_drop_count", int'(drop_count), 0);
    ratio_load = 1'b0; in_valid = 1'b0;
    rst_n = 1'b1;
    step(); step();

    // R=4 continuous input, then R=1 toggling input
    vecs[0]  = '{1'b1, 8'd4, 1'b1, 1'b0, 2'b01};
    vecs[1]  = '{1'b0, 8'd0, 1'b1, 1'b0, 2'b01};
    vecs[2]  = '{1'b0, 8'd0, 1'b1, 1'b0, 2'b01};
    vecs[3]  = '{1'b0, 8'd0, 1'b1, 1'b0, 2'b01};
    vecs[4]  = '{1'b0, 8'd0, 1'b1, 1'b1, 2'b01};
    vecs[5]  = '{1'b0, 8'd0, 1'b0, 1'b0, 2'b01};
    vecs[6]  = '{1'b0, 8'd0, 1'b1, 1'b0, 2'b01};
    vecs[7]  = '{1'b0, 8'd0, 1'b1, 1'b0, 2'b01};
    vecs[8]  = '{1'b0, 8'd0, 1'b1, 1'b0, 2'b01};
    vecs[9]  = '{1'b0, 8'd0, 1'b1, 1'b1, 2'b01};
    vecs[10] = '{1'b1, 8'd1, 1'b1, 1'b0, 2'b01};
    vecs[11] = '{1'b0, 8'd0, 1'b1, 1'b1, 2'b01};
    vecs[12] = '{1'b0, 8'd0, 1'b0, 1'b0, 2'b01};
    vecs[13] = '{1'b0, 8'd0, 1'b1, 1'b1, 2'b01};
    vecs[14] = '{1'b0, 8'd0, 1'b0, 1'b0, 2'b01};
    vecs[15] = '{1'b0, 8'd0, 1'b0, 1'b0, 2'b01};
    vecs[16] = '{1'b0, 8'd0, 1'b1, 1'b1, 2'b01};
    for (int i = 0; i < 17; i++) begin
      ratio_load = vecs[i].load;
      ratio      = vecs[i].ratio;
      in_valid   = vecs[i].iv;
      step();
      check($sformatf("vec%0d_decim_strobe", i), int'(decim_strobe), int'(vecs[i].exp_strobe));
      check($sformatf("vec%0d_comp_in_valid", i), int'(bus.comp_in_valid), int'(vecs[i].exp_strobe));
      check($sformatf("vec%0d_state", i), int'(state), int'(vecs[i].exp_state));
      check($sformatf("vec%0d_out_valid", i), int'(bus.out_valid), 0);
    end

    // Warm-up discard with compensator model, R=2
    ratio_load = 1'b0; in_valid = 1'b0;
    repeat (4) step();
    model_mode = 1'b1;
    ratio = 8'd2; ratio_load = 1'b1; in_valid = 1'b1;
    step();
    ratio_load = 1'b0;
    check("warm_load_state", int'(state), 1);
    occ = 0;
    for (int cyc = 0; cyc < 80 && occ < 7; cyc++) begin
      if (bus.comp_out_valid) begin
        occ++;
        if (occ <= 6) begin
          check($sformatf("warm_hidden%0d_out_valid", occ), int'(bus.out_valid), 0);
          check($sformatf("warm_hidden%0d_state", occ), int'(state), 1);
        end else begin
          check("warm_first_fwd_out_valid", int'(bus.out_valid), 1);
          check("warm_first_fwd_state", int'(state), 2);
        end
      end
      if (occ < 7) step();
    end
    check("warm_outputs_seen", occ, 7);

    // Backpressure in RUN: every strobe is dropped
    in_valid = 1'b0;
    repeat (4) step();
    model_mode = 1'b0; force_cov = 1'b1; bus.out_ready = 1'b0;
    strobes = 0; issues = 0;
    for (int i = 0; i < 14; i++) begin
      in_valid = (i < 10);
      step();
      if (decim_strobe) strobes++;
      if (bus.comp_in_valid) issues++;
    end
`ifdef CIC_DECIM_SEQUENCER_DROP_COUNT_EN
    exp_drop = 5;
`else
    exp_drop = 0;
`endif
    check("drop_strobes", strobes, 5);
    check("drop_issues", issues, 0);
    check("drop_count", int'(drop_count), exp_drop);
    check("drop_comp_out_ready", int'(bus.comp_out_ready), 0);
    check("drop_out_valid", int'(bus.out_valid), 1);
    check("drop_state", int'(state), 2);

    // Mid-RUN load of R=0, then restart with R=3
    force_cov = 1'b0;
    in_valid = 1'b1; ratio = 8'd0; ratio_load = 1'b1;
    step();
    ratio_load = 1'b0;
    check("r0_state", int'(state), 0);
    check("r0_decim_strobe", int'(decim_strobe), 0);
    strobes = 0;
    repeat (6) begin
      step();
      if (decim_strobe) strobes++;
    end
    check("r0_no_strobes", strobes, 0);
    check("r0_idle_comp_out_ready", int'(bus.comp_out_ready), 1);
    ratio = 8'd3; ratio_load = 1'b1;
    step();
    ratio_load = 1'b0;
    check("r3_state", int'(state), 1);
    check("r3_decim_strobe_load", int'(decim_strobe), 0);
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("r3_k%0d_decim_strobe", k), int'(decim_strobe), (k % 3 == 0) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
